// File: rtl/meikyuu_pkg.sv
// Shared direction codes, repeat-FSM encoding and the button conflict resolver for the maze input stage.
package meikyuu_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_e;

  typedef struct packed {
    logic       vld;
    logic [1:0] dir;
  } resolve_t;

  // held is {right,left,down,up}; opposing pairs cancel, then up > down > left > right.
  function automatic resolve_t resolve_dir(input logic [3:0] h);
    resolve_t r;
    logic up, dn, lf, rt;
    up = h[0] & ~h[1];
    dn = h[1] & ~h[0];
    lf = h[2] & ~h[3];
    rt = h[3] & ~h[2];
    r.vld = up | dn | lf | rt;
    if (up)      r.dir = DIR_UP;
    else if (dn) r.dir = DIR_DOWN;
    else if (lf) r.dir = DIR_LEFT;
    else         r.dir = DIR_RIGHT;
    return r;
  endfunction

endpackage

// File: rtl/meikyuu_btn_debounce.sv
// One button: 2-FF synchroniser, optional inversion, then a stable level that changes only after
// DEBOUNCE_CYCLES consecutive disagreeing cycles. Level changes DEBOUNCE_CYCLES+2 cycles after the raw edge; no backpressure.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          synced;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Sync flops reset to the raw "released" level so nothing is seen as a press after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= {BTN_ACTIVE_LOW, BTN_ACTIVE_LOW};
    else         sync_q <= {sync_q[0], btn_i};
  end

  assign synced = sync_q[1] ^ BTN_ACTIVE_LOW;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = synced;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level_o = stable_q;

endmodule

// File: rtl/meikyuu_input.sv
// Maze input stage: debounced buttons -> resolved direction -> press/auto-repeat move events.
// First event one cycle after the debounced press; events arriving while an unaccepted one is pending are dropped.
module meikyuu_input
  import meikyuu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 6250000,
  parameter int REPEAT_PERIOD   = 2500000,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic       CLOCK_25,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [3:0] held
);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] DELAY_LD  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LD = TW'(REPEAT_PERIOD - 1);

  logic [3:0] btn_raw;
  assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_db (
      .clk_i  (CLOCK_25),
      .rst_ni (reset_n),
      .btn_i  (btn_raw[i]),
      .level_o(held[i])
    );
  end

  resolve_t      res;
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    last_dir_q, last_dir_d;
  logic          issue;
  logic          accept;
  logic          move_valid_q;
  logic [1:0]    move_dir_q;

  assign res = resolve_dir(held);

  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      last_dir_q <= DIR_UP;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      last_dir_q <= last_dir_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    last_dir_d = last_dir_q;
    case (state_q)
      ST_IDLE: begin
        if (res.vld) begin
          state_d    = ST_HOLD;
          timer_d    = DELAY_LD;
          last_dir_d = res.dir;
        end
      end
      default: begin
        if (!res.vld) begin
          state_d = ST_IDLE;
        end else if (res.dir != last_dir_q) begin
          state_d    = ST_HOLD;
          timer_d    = DELAY_LD;
          last_dir_d = res.dir;
        end else if (timer_q == '0) begin
          state_d = ST_REPEAT;
          timer_d = PERIOD_LD;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
    endcase
  end

  always_comb begin
    issue = 1'b0;
    case (state_q)
      ST_IDLE: issue = res.vld;
      default: issue = res.vld && ((res.dir != last_dir_q) || (timer_q == '0));
    endcase
  end

  // The repeat schedule keeps running even when an event is dropped for lack of move_ready.
  assign accept = issue && (!move_valid_q || move_ready);

  always_ff @(posedge CLOCK_25 or negedge reset_n) begin
    if (!reset_n) begin
      move_valid_q <= 1'b0;
      move_dir_q   <= DIR_UP;
    end else if (accept) begin
      move_valid_q <= 1'b1;
      move_dir_q   <= res.dir;
    end else if (move_valid_q && move_ready) begin
      move_valid_q <= 1'b0;
    end
  end

  assign move_valid = move_valid_q;
  assign move_dir   = move_dir_q;

endmodule

// File: tb/tb_meikyuu_input.sv
// Directed bench for meikyuu_input with short debounce/repeat timings; expected cycles are hand-derived.
module tb_meikyuu_input;

  logic       CLOCK_25 = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       move_ready = 1'b0;
  logic       move_valid;
  logic [1:0] move_dir;
  logic [3:0] held;

  int now = 0;
  int t0 = 0;
  int passed = 0;
  int fails = 0;
  int total = 0;

  meikyuu_input #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5),
    .BTN_ACTIVE_LOW (1'b0)
  ) dut (
    .CLOCK_25  (CLOCK_25),
    .reset_n   (reset_n),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .move_ready(move_ready),
    .move_valid(move_valid),
    .move_dir  (move_dir),
    .held      (held)
  );

  always #5 CLOCK_25 = ~CLOCK_25;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passed, total);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, now - t0);
    end
  endtask

  // Observation point: 1 ns after a rising edge; values driven here are present for the whole cycle.
  task automatic cyc();
    @(posedge CLOCK_25);
    #1;
    now++;
  endtask

  task automatic at(input int c);
    while (now < t0 + c) cyc();
  endtask

  task automatic run_count(input int n, output int pulses, output logic [3:0] held_or);
    pulses  = 0;
    held_or = '0;
    repeat (n) begin
      cyc();
      if (move_valid === 1'b1) pulses++;
      held_or = held_or | held;
    end
  endtask

  initial begin
    int p;
    int good;
    logic [3:0] h;

    // Reset state
    repeat (2) cyc();
    chk("rst_valid", 32'(move_valid), 0);
    chk("rst_dir",   32'(move_dir),   0);
    chk("rst_held",  32'(held),       0);
    reset_n = 1'b1;
    repeat (2) cyc();
    chk("post_rst_valid", 32'(move_valid), 0);

    // 1: a 3-cycle glitch is one short of the debounce threshold
    t0 = now; btn_up = 1'b1;
    at(3); btn_up = 1'b0;
    run_count(15, p, h);
    chk("t1_pulses", 32'(p), 0);
    chk("t1_held",   32'(h), 0);

    // 2: right held, ready high: events at 7, 17, 22, 27, 32
    t0 = now; btn_right = 1'b1; move_ready = 1'b1;
    at(6);  chk("t2_held6", 32'(held), 32'h8);
            chk("t2_v6",    32'(move_valid), 0);
    at(7);  chk("t2_v7",    32'(move_valid), 1);
            chk("t2_d7",    32'(move_dir), 3);
    at(8);  chk("t2_v8",    32'(move_valid), 0);
    at(16); chk("t2_v16",   32'(move_valid), 0);
    at(17); chk("t2_v17",   32'(move_valid), 1);
    at(22); chk("t2_v22",   32'(move_valid), 1);
    at(27); chk("t2_v27",   32'(move_valid), 1);
            chk("t2_d27",   32'(move_dir), 3);
    btn_right = 1'b0;
    at(32); chk("t2_v32",   32'(move_valid), 1);
    at(33); chk("t2_held33", 32'(held), 0);
            chk("t2_v33",    32'(move_valid), 0);
    run_count(12, p, h);
    chk("t2_no_more", 32'(p), 0);

    // 3: up+down cancel; releasing down leaves up
    t0 = now; btn_up = 1'b1; btn_down = 1'b1;
    at(6);  chk("t3_held_ud", 32'(held), 32'h3);
    at(8);  chk("t3_v_cancel", 32'(move_valid), 0);
    at(10); btn_down = 1'b0; t0 = now;
    at(6);  chk("t3_held_u", 32'(held), 32'h1);
            chk("t3_v6",     32'(move_valid), 0);
    at(7);  chk("t3_v7",     32'(move_valid), 1);
            chk("t3_d7",     32'(move_dir), 0);
    at(16); chk("t3_v16",    32'(move_valid), 0);
    at(17); chk("t3_v17",    32'(move_valid), 1);
    at(22); chk("t3_v22",    32'(move_valid), 1);
    btn_up = 1'b0;
    repeat (20) cyc();
    chk("t3_idle_held", 32'(held), 0);
    chk("t3_idle_v",    32'(move_valid), 0);

    // 4: left with ready low; pending event holds, repeats dropped
    t0 = now; btn_left = 1'b1; move_ready = 1'b0;
    at(7);  chk("t4_v7", 32'(move_valid), 1);
            chk("t4_d7", 32'(move_dir), 2);
    good = 0;
    repeat (17) begin
      cyc();
      if (move_valid === 1'b1 && move_dir === 2'b10) good++;
    end
    chk("t4_hold_8_24", 32'(good), 17);
    at(25); move_ready = 1'b1;
    at(26); chk("t4_v26_cleared", 32'(move_valid), 0);
    move_ready = 1'b0;
    at(27); chk("t4_v27", 32'(move_valid), 1);
            chk("t4_d27", 32'(move_dir), 2);
    at(31); move_ready = 1'b1;
    at(32); chk("t4_v32_back2back", 32'(move_valid), 1);
    btn_left = 1'b0;
    at(33); chk("t4_v33", 32'(move_valid), 0);
    at(37); chk("t4_v37", 32'(move_valid), 1);
    at(38); chk("t4_v38", 32'(move_valid), 0);
            chk("t4_held38", 32'(held), 0);
    repeat (10) cyc();

    // 5: right into REPEAT, then switch to up
    t0 = now; btn_right = 1'b1; move_ready = 1'b1;
    at(17); chk("t5_v17", 32'(move_valid), 1);
    at(18); btn_right = 1'b0; btn_up = 1'b1; t0 = now;
    at(4);  chk("t5_v_r22", 32'(move_valid), 1);
            chk("t5_d_r22", 32'(move_dir), 3);
    at(6);  chk("t5_held6", 32'(held), 32'h1);
            chk("t5_v6",    32'(move_valid), 0);
    at(7);  chk("t5_v7",    32'(move_valid), 1);
            chk("t5_d7",    32'(move_dir), 0);
    at(9);  chk("t5_v9_old_sched", 32'(move_valid), 0);
    at(16); chk("t5_v16",   32'(move_valid), 0);
    at(17); chk("t5_v17_restart", 32'(move_valid), 1);
            chk("t5_d17",   32'(move_dir), 0);

    // 6: async reset in REPEAT with up still pressed
    at(19);
    reset_n = 1'b0;
    #1;
    chk("t6_async_v",    32'(move_valid), 0);
    chk("t6_async_held", 32'(held), 0);
    repeat (3) cyc();
    reset_n = 1'b1; t0 = now;
    at(5); chk("t6_held5", 32'(held), 0);
    at(6); chk("t6_held6", 32'(held), 32'h1);
           chk("t6_v6",    32'(move_valid), 0);
    at(7); chk("t6_v7",    32'(move_valid), 1);
           chk("t6_d7",    32'(move_dir), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
